dc_motor_pwm_core: RTL
======================

Name: dc_motor_pwm_core

Overview:
- Downstream of the MY_DC_MOTOR AXI4-Lite slave register file.
- Consumes the control words written over S00_AXI (enable, direction, duty, period, prescale) and produces the H-bridge drive pair for one DC motor.
- Provides glitch-free PWM, shadow-register updates at period boundaries, and a dead-time interlock on direction reversal.
- Status outputs are fed back into the readable register space.

Parameters:
- PWM_WIDTH, 16: width of the duty, period and period-counter fields.
- PRESCALE_WIDTH, 16: width of the clock prescaler divider.
- DEADTIME_CYCLES, 100: s00_axi_aclk cycles with both bridge inputs low on a direction change; must be ≥1.

Ports:
- s00_axi_aclk  in  1  system clock; same clock as the AXI slave.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- ctrl_enable  in  1  motor enable (slv_reg0[0]).
- ctrl_dir  in  1  requested direction, 0=forward, 1=reverse (slv_reg0[1]).
- ctrl_duty  in  PWM_WIDTH  requested high-time in PWM ticks (slv_reg1).
- ctrl_period  in  PWM_WIDTH  PWM period in ticks (slv_reg2).
- ctrl_prescale  in  PRESCALE_WIDTH  tick divider, tick every ctrl_prescale+1 clocks (slv_reg3).
- ctrl_update  in  1  one-cycle pulse on any write to slv_reg1..3.
- pwm_a  out  1  H-bridge input A (forward leg).
- pwm_b  out  1  H-bridge input B (reverse leg).
- period_tick  out  1  one-cycle pulse at each PWM period boundary.
- status_busy  out  1  high while in DEAD state.
- status_dir  out  1  direction actually being driven.

Behaviour:
- Reset (async assert, sync release): pwm_a=0, pwm_b=0, period_tick=0, status_busy=0, status_dir=0.
  - Prescaler, period counter and shadow duty/period/prescale cleared; state=IDLE; update_pending=0.
- Prescaler: counts 0..shadow_prescale; tick when count==shadow_prescale, then wraps to 0. shadow_prescale=0 gives a tick every clock.
- Period counter: advances on tick over 0..shadow_period-1. At wrap (or from 0 when shadow_period≤1), period_tick pulses for one clock.
- Shadow load: ctrl_update sets update_pending.
  - On the period_tick cycle with update_pending=1, shadow duty/period/prescale take the live ctrl_* values and update_pending clears.
  - ctrl_update coincident with period_tick: load happens on that same boundary.
  - In IDLE, ctrl_* values load into the shadows every cycle.
- PWM level: pwm_raw = (cnt < shadow_duty).
  - shadow_duty ≥ shadow_period gives constant high (100%).
  - shadow_duty=0 gives constant low.
  - shadow_period=0 gives pwm_raw=0 and a held counter.
  - pwm_a/pwm_b are registered: one clock latency from counter to pin.
- FSM:
  - IDLE: outputs low, counters held at 0. ctrl_enable=1 → RUN with status_dir=ctrl_dir; counter starts at 0.
  - RUN: the pwm_raw leg selected by status_dir is driven (pwm_a if 0, pwm_b if 1); the other leg is held 0. ctrl_dir≠status_dir → DEAD. ctrl_enable=0 → IDLE.
  - DEAD: both outputs 0, status_busy=1, deadtime counter runs DEADTIME_CYCLES clocks. On expiry: status_dir=ctrl_dir, counter reset to 0, → RUN.
    - ctrl_enable=0 during DEAD → IDLE, with status_dir updated.
    - Direction flipping back during DEAD does not shorten the dead time.
- Invariant: pwm_a and pwm_b are never 1 in the same cycle, in any state and across reset.
- ctrl_enable deassert takes effect on the next clock edge (outputs low one cycle later). No waiting for a period boundary.

Optional Feature:
- Macro: DC_MOTOR_SOFT_START_EN.
- Defined:
  - An internal duty_eff register ramps toward shadow_duty by ±1 per period_tick; PWM compares against duty_eff.
  - duty_eff resets to 0 on entering RUN from IDLE or from DEAD.
  - status_busy is also high while duty_eff≠shadow_duty in RUN.
- Undefined: duty_eff ≡ shadow_duty; no ramp logic synthesised.

Test Plan:
- Basic forward PWM: prescale=0, period=10, duty=3, dir=0, enable=1 → pwm_a high 3 of every 10 clocks, pwm_b=0, period_tick every 10 clocks, first rising edge of pwm_a 2 clocks after enable.
- Shadow timing: running period=10/duty=3, write duty=7 mid-period → width stays 3 until the next period_tick, then 7. Period=10/duty=12 → constant high. Duty=0 → constant low.
- Reversal with DEADTIME_CYCLES=100: dir 0→1 while running → both outputs 0 and status_busy=1 for exactly 100 clocks, then pwm_b pulses and status_dir=1. pwm_a&pwm_b never both 1 (assertion over whole run).
- Prescale and edge cases: prescale=4, period=4, duty=2 → pwm high 10 clocks of every 20. Period=0 → outputs low, no period_tick.
- Reset/disable mid-operation: deassert s00_axi_aresetn mid-DEAD → outputs 0 immediately (asynchronous), state IDLE after release. ctrl_enable=0 mid-RUN → outputs 0 on next clock.
- With DC_MOTOR_SOFT_START_EN: period=10, duty=5 from IDLE → pulse widths 0,1,2,3,4,5,5… over successive periods; status_busy drops when the width reaches 5.

Source files
------------

// File: rtl/dc_motor_pwm_core.sv
// dc_motor_pwm_core: H-bridge PWM driver with period-boundary shadow updates and dead-time on reversal.
// Define DC_MOTOR_SOFT_START_EN to ramp the effective duty by one step per PWM period.
module dc_motor_pwm_core #(
  parameter int PWM_WIDTH       = 16,
  parameter int PRESCALE_WIDTH  = 16,
  parameter int DEADTIME_CYCLES = 100
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  input  logic                      ctrl_enable,
  input  logic                      ctrl_dir,
  input  logic [PWM_WIDTH-1:0]      ctrl_duty,
  input  logic [PWM_WIDTH-1:0]      ctrl_period,
  input  logic [PRESCALE_WIDTH-1:0] ctrl_prescale,
  input  logic                      ctrl_update,
  output logic                      pwm_a,
  output logic                      pwm_b,
  output logic                      period_tick,
  output logic                      status_busy,
  output logic                      status_dir
);
  localparam int DW = $clog2(DEADTIME_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  state_t                    state_q;
  logic [PRESCALE_WIDTH-1:0] psc_q, sh_prescale_q;
  logic [PWM_WIDTH-1:0]      cnt_q, sh_duty_q, sh_period_q, duty_eff;
  logic [DW-1:0]             dead_q;
  logic                      pend_q, pwm_a_q, pwm_b_q, busy_q, dir_q;
  logic                      tick, wrap, pend, load, pwm_raw, ramp_busy;

  assign tick        = state_q == RUN && psc_q == sh_prescale_q;
  assign wrap        = sh_period_q <= PWM_WIDTH'(1) || cnt_q >= sh_period_q - PWM_WIDTH'(1);
  assign period_tick = tick && sh_period_q != '0 && wrap;
  assign pend        = pend_q | ctrl_update;
  assign load        = state_q == IDLE || (period_tick && pend);
  assign pwm_raw     = sh_period_q != '0 && cnt_q < duty_eff;
  assign pwm_a       = pwm_a_q;
  assign pwm_b       = pwm_b_q;
  assign status_busy = busy_q;
  assign status_dir  = dir_q;

`ifdef DC_MOTOR_SOFT_START_EN
  logic [PWM_WIDTH-1:0] duty_eff_q;
  // Held at zero outside RUN so every entry into RUN restarts the ramp.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) duty_eff_q <= '0;
    else if (state_q != RUN) duty_eff_q <= '0;
    else if (period_tick && duty_eff_q != sh_duty_q)
      duty_eff_q <= duty_eff_q < sh_duty_q ? duty_eff_q + 1'b1 : duty_eff_q - 1'b1;
  assign duty_eff  = duty_eff_q;
  assign ramp_busy = state_q == RUN && duty_eff_q != sh_duty_q;
`else
  assign duty_eff  = sh_duty_q;
  assign ramp_busy = 1'b0;
`endif

  // Both legs derive from the single dir_q register, so they can never be high together.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      state_q       <= IDLE;
      psc_q         <= '0;
      cnt_q         <= '0;
      dead_q        <= '0;
      sh_duty_q     <= '0;
      sh_period_q   <= '0;
      sh_prescale_q <= '0;
      pend_q        <= 1'b0;
      pwm_a_q       <= 1'b0;
      pwm_b_q       <= 1'b0;
      busy_q        <= 1'b0;
      dir_q         <= 1'b0;
    end else begin
      pwm_a_q <= state_q == RUN && !dir_q && pwm_raw;
      pwm_b_q <= state_q == RUN && dir_q && pwm_raw;
      busy_q  <= state_q == DEAD || ramp_busy;
      pend_q  <= state_q != IDLE && pend && !period_tick;
      if (load) begin
        sh_duty_q     <= ctrl_duty;
        sh_period_q   <= ctrl_period;
        sh_prescale_q <= ctrl_prescale;
      end
      psc_q  <= '0;
      cnt_q  <= '0;
      dead_q <= '0;
      case (state_q)
        IDLE: if (ctrl_enable) begin
          state_q <= RUN;
          dir_q   <= ctrl_dir;
        end
        RUN: if (!ctrl_enable) state_q <= IDLE;
        else if (ctrl_dir != dir_q) state_q <= DEAD;
        else begin
          psc_q <= tick ? '0 : psc_q + 1'b1;
          cnt_q <= tick && sh_period_q != '0 ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        end
        DEAD: if (!ctrl_enable) begin
          state_q <= IDLE;
          dir_q   <= ctrl_dir;
        end else if (dead_q == DW'(DEADTIME_CYCLES - 1)) begin
          state_q <= RUN;
          dir_q   <= ctrl_dir;
        end else dead_q <= dead_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
endmodule
